// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - UART-style frame serializer: start, DATA_W payload bits, optional parity, STOP_BITS stop bits
// Optional parity bit compiled in when UART_TX_PARITY_EN is defined.
module uart_tx_serializer #(
  parameter int DATA_W     = 8,
  parameter int STOP_BITS  = 1,
  parameter int MSB_FIRST  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              baud_tick,
  input  logic              tx_en,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              tx_out,
  output logic              busy,
  output logic              char_sent
);

  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START_WAIT,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] shreg, shreg_nxt;
  logic [CW-1:0]     bit_cnt, bit_cnt_nxt;
  logic [0:0]        stop_cnt, stop_cnt_nxt;
  logic              tx_out_nxt, busy_nxt, char_sent_nxt;
  logic              qual;
`ifdef UART_TX_PARITY_EN
  logic              parity_q, parity_nxt;
`endif

  // Payload is stored in line order so the datapath always shifts out bit 0.
  function automatic logic [DATA_W-1:0] line_order(input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W; i++) begin
      r[i] = (MSB_FIRST != 0) ? d[DATA_W-1-i] : d[i];
    end
    return r;
  endfunction

  assign qual     = baud_tick && tx_en;
  assign tx_ready = (state == IDLE);

  always_comb begin
    state_nxt     = state;
    shreg_nxt     = shreg;
    bit_cnt_nxt   = bit_cnt;
    stop_cnt_nxt  = stop_cnt;
    tx_out_nxt    = tx_out;
    busy_nxt      = busy;
    char_sent_nxt = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_nxt    = parity_q;
`endif
    case (state)
      IDLE: begin
        busy_nxt = tx_valid;
        if (tx_valid) begin
          shreg_nxt = line_order(tx_data);
`ifdef UART_TX_PARITY_EN
          parity_nxt = (^tx_data) ^ (PARITY_ODD != 0);
`endif
          state_nxt = START_WAIT;
        end
      end
      START_WAIT: begin
        if (qual) begin
          tx_out_nxt = 1'b0;
          state_nxt  = START;
        end
      end
      START: begin
        if (qual) begin
          tx_out_nxt  = shreg[0];
          shreg_nxt   = shreg >> 1;
          bit_cnt_nxt = '0;
          state_nxt   = DATA;
        end
      end
      DATA: begin
        if (qual) begin
          if (bit_cnt == CW'(DATA_W - 1)) begin
`ifdef UART_TX_PARITY_EN
            tx_out_nxt = parity_q;
            state_nxt  = PARITY;
`else
            tx_out_nxt   = 1'b1;
            stop_cnt_nxt = '0;
            state_nxt    = STOP;
`endif
          end else begin
            tx_out_nxt  = shreg[0];
            shreg_nxt   = shreg >> 1;
            bit_cnt_nxt = bit_cnt + CW'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (qual) begin
          tx_out_nxt   = 1'b1;
          stop_cnt_nxt = '0;
          state_nxt    = STOP;
        end
      end
`endif
      STOP: begin
        // busy stays high through the char_sent cycle; IDLE clears it next.
        if (qual) begin
          if (stop_cnt == 1'(STOP_BITS - 1)) begin
            char_sent_nxt = 1'b1;
            state_nxt     = IDLE;
          end else begin
            stop_cnt_nxt = stop_cnt + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      stop_cnt  <= '0;
      tx_out    <= 1'b1;
      busy      <= 1'b0;
      char_sent <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      shreg     <= shreg_nxt;
      bit_cnt   <= bit_cnt_nxt;
      stop_cnt  <= stop_cnt_nxt;
      tx_out    <= tx_out_nxt;
      busy      <= busy_nxt;
      char_sent <= char_sent_nxt;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb/tb_uart_tx_serializer.sv - scoreboard bench for uart_tx_serializer
`timescale 1ns/1ps
module tb_uart_tx_serializer;

`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       baud_tick = 1'b0;
  logic       tx_en = 1'b1;
  logic       tx_valid_a = 1'b0, tx_valid_b = 1'b0;
  logic [7:0] tx_data_a = '0, tx_data_b = '0;
  logic       tx_ready_a, tx_out_a, busy_a, char_sent_a;
  logic       tx_ready_b, tx_out_b, busy_b, char_sent_b;

  uart_tx_serializer #(.DATA_W(8), .STOP_BITS(1), .MSB_FIRST(1), .PARITY_ODD(0)) dut_a (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_en(tx_en),
    .tx_valid(tx_valid_a), .tx_data(tx_data_a), .tx_ready(tx_ready_a),
    .tx_out(tx_out_a), .busy(busy_a), .char_sent(char_sent_a));

  uart_tx_serializer #(.DATA_W(8), .STOP_BITS(2), .MSB_FIRST(0), .PARITY_ODD(1)) dut_b (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_en(tx_en),
    .tx_valid(tx_valid_b), .tx_data(tx_data_b), .tx_ready(tx_ready_b),
    .tx_out(tx_out_b), .busy(busy_b), .char_sent(char_sent_b));

  always #5 clk = ~clk;

  typedef struct packed {logic b; logic cs; logic first;} exp_t;
  exp_t qa[$];
  exp_t qb[$];
  int   checks = 0, fails = 0;
  int   tick_no = 0;
  logic hit_a = 1'b0, hit_b = 1'b0;
  int   pops_a = 0, cs_cnt_a = 0, cs_cnt_b = 0;
  int   st_a = 0, st_b = 0, cs_tick_b = 0;
  logic gap_chk = 1'b0, gap_armed = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Expected line value after each qualified tick while busy, last entry carries char_sent.
  task automatic push_frame(input bit to_b, input logic [7:0] d, input bit msb,
                            input int stops, input bit odd);
    exp_t e;
    e = '{b: 1'b0, cs: 1'b0, first: 1'b1};
    if (to_b) qb.push_back(e); else qa.push_back(e);
    for (int i = 0; i < 8; i++) begin
      e = '{b: (msb ? d[7-i] : d[i]), cs: 1'b0, first: 1'b0};
      if (to_b) qb.push_back(e); else qa.push_back(e);
    end
    if (P == 1) begin
      e = '{b: (^d) ^ odd, cs: 1'b0, first: 1'b0};
      if (to_b) qb.push_back(e); else qa.push_back(e);
    end
    for (int s = 0; s < stops; s++) begin
      e = '{b: 1'b1, cs: 1'b0, first: 1'b0};
      if (to_b) qb.push_back(e); else qa.push_back(e);
    end
    e = '{b: 1'b1, cs: 1'b1, first: 1'b0};
    if (to_b) qb.push_back(e); else qa.push_back(e);
  endtask

  // Free-running baud strobe, one clk in every four.
  initial begin
    int tc = 0;
    forever begin
      @(negedge clk);
      tc++;
      baud_tick = (tc % 4 == 0);
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      hit_a = baud_tick && tx_en && busy_a && rst;
      hit_b = baud_tick && tx_en && busy_b && rst;
      if (baud_tick && tx_en) tick_no++;
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (char_sent_a) cs_cnt_a++;
      if (hit_a) begin
        if (qa.size() == 0) chk("a_unexpected_tick", 1, 0);
        else begin
          e = qa.pop_front();
          pops_a++;
          chk("a_tx_out", int'(tx_out_a), int'(e.b));
          chk("a_char_sent", int'(char_sent_a), int'(e.cs));
          if (e.first) st_a = tick_no;
          if (e.cs) chk("a_frame_ticks", tick_no - st_a, 1 + 8 + P + 1);
        end
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (char_sent_b) cs_cnt_b++;
      if (hit_b) begin
        if (qb.size() == 0) chk("b_unexpected_tick", 1, 0);
        else begin
          e = qb.pop_front();
          chk("b_tx_out", int'(tx_out_b), int'(e.b));
          chk("b_char_sent", int'(char_sent_b), int'(e.cs));
          if (e.first) begin
            st_b = tick_no;
            if (gap_armed) begin
              chk("b_back_to_back_gap", tick_no - cs_tick_b, 1);
              gap_armed = 1'b0;
            end
          end
          if (e.cs) begin
            chk("b_frame_ticks", tick_no - st_b, 1 + 8 + P + 2);
            cs_tick_b = tick_no;
            if (gap_chk) gap_armed = 1'b1;
          end
        end
      end
    end
  end

  task automatic send_a(input logic [7:0] d);
    int n = 0;
    while (!tx_ready_a && n < 400) begin @(negedge clk); n++; end
    if (n >= 400) chk("a_ready_timeout", 1, 0);
    tx_valid_a = 1'b1;
    tx_data_a  = d;
    push_frame(1'b0, d, 1'b1, 1, 1'b0);
    @(negedge clk);
    tx_valid_a = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] d, input bit keep);
    int n = 0;
    while (!tx_ready_b && n < 400) begin @(negedge clk); n++; end
    if (n >= 400) chk("b_ready_timeout", 1, 0);
    tx_valid_b = 1'b1;
    tx_data_b  = d;
    push_frame(1'b1, d, 1'b0, 2, 1'b1);
    @(negedge clk);
    if (!keep) tx_valid_b = 1'b0;
  endtask

  task automatic wait_done;
    int n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) chk("drain_timeout", 1, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_pops_a(input int target);
    int n = 0;
    while (pops_a < target && n < 400) begin @(negedge clk); #1; n++; end
    if (n >= 400) chk("a_pop_timeout", 1, 0);
  endtask

  initial begin
    int   base, saved_cs;
    logic saved, frozen;
    repeat (3) @(negedge clk);
    chk("rst_tx_out_a", int'(tx_out_a), 1);
    chk("rst_busy_a", int'(busy_a), 0);
    chk("rst_ready_a", int'(tx_ready_a), 1);
    chk("rst_char_sent_a", int'(char_sent_a), 0);
    chk("rst_tx_out_b", int'(tx_out_b), 1);
    chk("rst_ready_b", int'(tx_ready_b), 1);
    rst = 1'b1;
    @(negedge clk);

    send_a(8'h01);
    wait_done();
    send_b(8'h01, 1'b0);
    wait_done();
    send_a(8'h07);
    send_b(8'h07, 1'b0);
    wait_done();

    gap_chk = 1'b1;
    send_b(8'hA5, 1'b1);
    send_b(8'h5A, 1'b0);
    wait_done();
    gap_chk = 1'b0;

    // Freeze during a data bit, then resume.
    base = pops_a;
    send_a(8'h3C);
    wait_pops_a(base + 5);
    tx_en  = 1'b0;
    saved  = tx_out_a;
    frozen = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (tx_out_a !== saved || busy_a !== 1'b1) frozen = 1'b0;
    end
    chk("a_frozen_while_disabled", int'(frozen), 1);
    tx_en = 1'b1;
    wait_done();

    // Abort mid-frame with reset; line drops while a 0 data bit is on it.
    base = pops_a;
    send_a(8'h90);
    wait_pops_a(base + 7);
    chk("a_line_low_before_abort", int'(tx_out_a), 0);
    saved_cs = cs_cnt_a;
    rst = 1'b0;
    #1;
    chk("abort_tx_out", int'(tx_out_a), 1);
    chk("abort_busy", int'(busy_a), 0);
    chk("abort_ready", int'(tx_ready_a), 1);
    qa.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    chk("abort_no_char_sent", cs_cnt_a - saved_cs, 0);

    send_a(8'h5A);
    wait_done();

    chk("a_char_sent_total", cs_cnt_a, 4);
    chk("b_char_sent_total", cs_cnt_b, 4);
    chk("a_queue_empty", qa.size(), 0);
    chk("b_queue_empty", qb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
